pipe_hazard_ctrl: RTL and testbench



---
 rtl/core_pkg.sv | 15 +
 rtl/hazard_fwd_unit.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the hazard/pipeline-control unit of the 5-stage core:
// forwarding select codes and the control FSM state encoding.
package core_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_RUN   = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational EX-stage operand forwarding select for one source register.
// M-stage results win over W-stage results; x0 is never forwarded.
module hazard_fwd_unit
  import core_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
      fwd_sel = FWD_M;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
      fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit: post-reset flush, memory-wait supervision,
// branch/load-use stall priority, forwarding selects and stall-cycle counting.
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic             reg_write_e,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             load_e,
  input  logic             pc_src_e,
  input  logic             mem_req_m,
  input  logic             mem_ready_m,
  output logic             En_F,
  output logic             En_D,
  output logic             En_E,
  output logic             En_M,
  output logic             En_W,
  output logic             Keep_D,
  output logic             Keep_E,
  output logic             Keep_W,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(FLUSH_CYCLES - 1);
  localparam logic [WT_W-1:0] WAIT_LAST  = WT_W'(MEM_TIMEOUT - 1);
  // With no flush cycles requested, reset lands directly in RUN.
  localparam state_e RESET_ST = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;

  state_e            state_q, state_d;
  logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [WT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

  logic              mem_stall;
  logic              load_use;
  logic [1:0]        fwd_a, fwd_b;

  assign mem_stall = mem_req_m & ~mem_ready_m;
  assign load_use  = load_e & reg_write_e & (rd_e != 5'd0) &
                     ((rd_e == rs1_d) | (rd_e == rs2_d));

  hazard_fwd_unit u_fwd_a (
    .rs_e(rs1_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .fwd_sel(fwd_a)
  );

  hazard_fwd_unit u_fwd_b (
    .rs_e(rs2_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .fwd_sel(fwd_b)
  );

  assign forward_a_e  = Rst_n ? fwd_a : FWD_RF;
  assign forward_b_e  = Rst_n ? fwd_b : FWD_RF;
  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;

  // Mealy stage control: mem stall > branch flush > load-use bubble.
  always_comb begin
    En_F   = 1'b1;
    En_D   = 1'b1;
    En_E   = 1'b1;
    En_M   = 1'b1;
    En_W   = 1'b1;
    Keep_D = 1'b1;
    Keep_E = 1'b1;
    Keep_W = 1'b1;
    if (!Rst_n || (state_q == ST_FLUSH)) begin
      En_F   = 1'b0;
      Keep_D = 1'b0;
      Keep_E = 1'b0;
      Keep_W = 1'b0;
    end else if (mem_stall) begin
      En_F   = 1'b0;
      En_D   = 1'b0;
      En_E   = 1'b0;
      En_M   = 1'b0;
      Keep_W = 1'b0;
    end else if (pc_src_e) begin
      Keep_D = 1'b0;
      Keep_E = 1'b0;
    end else if (load_use) begin
      En_F   = 1'b0;
      En_D   = 1'b0;
      Keep_E = 1'b0;
    end
  end

  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = mem_timeout_q;
    stall_cycles_d = stall_cycles_q;
    case (state_q)
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) state_d = ST_RUN;
        else flush_cnt_d = flush_cnt_q + FL_W'(1);
      end
      ST_RUN: begin
        if (mem_stall) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_stall) begin
          if (wait_cnt_q == WAIT_LAST) mem_timeout_d = 1'b1;
          else wait_cnt_d = wait_cnt_q + WT_W'(1);
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      default: state_d = RESET_ST;
    endcase
    if ((state_q != ST_FLUSH) && !En_F && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q        <= RESET_ST;
      flush_cnt_q    <= '0;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed corner
// sequences and randomized traffic against a behavioural reference model.
module tb_pipe_hazard_ctrl;
  import core_pkg::*;

  localparam int FLUSH_CYCLES = 2;
  localparam int MEM_TIMEOUT  = 4;
  localparam int CNT_W        = 5;
  localparam int STALL_MAX    = (1 << CNT_W) - 1;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic reg_write_e, reg_write_m, reg_write_w, load_e, pc_src_e, mem_req_m, mem_ready_m;
  logic En_F, En_D, En_E, En_M, En_W, Keep_D, Keep_E, Keep_W;
  logic [1:0] forward_a_e, forward_b_e;
  logic mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  always #5 Clk = ~Clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .load_e(load_e), .pc_src_e(pc_src_e), .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .En_F(En_F), .En_D(En_D), .En_E(En_E), .En_M(En_M), .En_W(En_W),
    .Keep_D(Keep_D), .Keep_E(Keep_E), .Keep_W(Keep_W),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  // Control word order: {En_F,En_D,En_E,En_M,En_W,Keep_D,Keep_E,Keep_W}
  localparam logic [7:0] C_NORM  = 8'hFF;
  localparam logic [7:0] C_LU    = 8'h3D;
  localparam logic [7:0] C_BR    = 8'hF9;
  localparam logic [7:0] C_MEM   = 8'h0E;
  localparam logic [7:0] C_FLUSH = 8'h78;

  int checks = 0;
  int errors = 0;

  // Reference model state (plain counters, not the DUT's encoding)
  int flush_left;
  int wait_run;
  int stalls;
  bit waiting;
  bit tmo;

  typedef struct {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic rw_e, rw_m, rw_w, ld, br, req, rdy;
    logic [7:0] exp_ctl;
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [7:0] ctl_word();
    return {En_F, En_D, En_E, En_M, En_W, Keep_D, Keep_E, Keep_W};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
    load_e = 0; pc_src_e = 0; mem_req_m = 0; mem_ready_m = 0;
  endtask

  task automatic model_reset();
    flush_left = FLUSH_CYCLES;
    wait_run = 0;
    stalls = 0;
    waiting = 0;
    tmo = 0;
  endtask

  function automatic logic [7:0] model_ctl();
    if (!Rst_n || flush_left > 0) return C_FLUSH;
    if (mem_req_m && !mem_ready_m) return C_MEM;
    if (pc_src_e) return C_BR;
    if (load_e && reg_write_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d)) return C_LU;
    return C_NORM;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (!Rst_n) return 2'b00;
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_tick(input logic [7:0] ctl);
    bit stall;
    if (flush_left > 0) begin
      flush_left--;
    end else begin
      stall = mem_req_m && !mem_ready_m;
      if (waiting) begin
        if (stall) begin
          wait_run++;
          if (wait_run >= MEM_TIMEOUT) tmo = 1;
        end else begin
          waiting = 0;
          wait_run = 0;
        end
      end else if (stall) begin
        waiting = 1;
      end
      if (!ctl[7] && stalls < STALL_MAX) stalls++;
    end
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic step(input string tag);
    logic [7:0] ctl;
    if (!Rst_n) model_reset();
    #2;
    ctl = model_ctl();
    cmp({tag, " ctl"}, 32'(ctl_word()), 32'(ctl));
    cmp({tag, " fwd_a"}, 32'(forward_a_e), 32'(model_fwd(rs1_e)));
    cmp({tag, " fwd_b"}, 32'(forward_b_e), 32'(model_fwd(rs2_e)));
    cmp({tag, " timeout"}, 32'(mem_timeout), 32'(tmo));
    cmp({tag, " stall_cycles"}, 32'(stall_cycles), 32'(stalls));
    @(posedge Clk);
    if (!Rst_n) model_reset();
    else model_tick(ctl);
    @(negedge Clk);
  endtask

  task automatic reset_seq();
    clear_inputs();
    Rst_n = 0;
    step("rst");
    Rst_n = 1;
    step("flush0");
    step("flush1");
  endtask

  initial begin
    // rs1_d rs2_d rs1_e rs2_e rd_e rd_m rd_w rw_e rw_m rw_w ld br req rdy ctl fa fb
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 2'b00, 2'b00};
    vecs[1]  = '{1, 5, 0, 0, 5, 0, 0, 1, 0, 0, 1, 0, 0, 0, C_LU,   2'b00, 2'b00};
    vecs[2]  = '{0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, C_NORM, 2'b00, 2'b00};
    vecs[3]  = '{5, 2, 0, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_NORM, 2'b00, 2'b00};
    vecs[4]  = '{5, 2, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, C_NORM, 2'b00, 2'b00};
    vecs[5]  = '{5, 2, 0, 0, 5, 0, 0, 1, 0, 0, 1, 1, 0, 0, C_BR,   2'b00, 2'b00};
    vecs[6]  = '{1, 2, 0, 0, 9, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_BR,   2'b00, 2'b00};
    vecs[7]  = '{5, 2, 0, 0, 5, 0, 0, 1, 0, 0, 1, 1, 1, 0, C_MEM,  2'b00, 2'b00};
    vecs[8]  = '{3, 6, 0, 0, 6, 0, 0, 1, 0, 0, 1, 0, 1, 1, C_LU,   2'b00, 2'b00};
    vecs[9]  = '{0, 0, 7, 3, 0, 7, 7, 0, 1, 1, 0, 0, 0, 0, C_NORM, 2'b10, 2'b00};
    vecs[10] = '{0, 0, 7, 3, 0, 7, 7, 0, 0, 1, 0, 0, 0, 0, C_NORM, 2'b01, 2'b00};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, C_NORM, 2'b00, 2'b00};
    vecs[12] = '{0, 0, 9, 7, 0, 7, 9, 0, 1, 1, 0, 0, 0, 0, C_NORM, 2'b01, 2'b10};
    vecs[13] = '{0, 0, 4, 4, 0, 4, 4, 0, 0, 0, 0, 0, 0, 0, C_NORM, 2'b00, 2'b00};
    vecs[14] = '{0, 0, 1, 7, 0, 7, 0, 0, 1, 0, 0, 0, 1, 0, C_MEM,  2'b00, 2'b10};
    vecs[15] = '{0, 0, 1, 7, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0, C_NORM, 2'b00, 2'b10};

    clear_inputs();
    model_reset();
    @(negedge Clk);

    // Reset with hostile inputs: forwarding and stall requests must be masked.
    rd_m = 7; reg_write_m = 1; rs1_e = 7; mem_req_m = 1;
    step("rst_a");
    step("rst_b");
    Rst_n = 1;
    load_e = 1; reg_write_e = 1; rd_e = 5; rs2_d = 5;
    step("flush0");
    step("flush1");
    clear_inputs();
    step("run0");
    cmp("post_flush stall_cycles", 32'(stall_cycles), 0);

    // Vector table, each row in RUN/WAIT
    for (int i = 0; i < 16; i++) begin
      rs1_d = vecs[i].rs1_d; rs2_d = vecs[i].rs2_d;
      rs1_e = vecs[i].rs1_e; rs2_e = vecs[i].rs2_e;
      rd_e = vecs[i].rd_e; rd_m = vecs[i].rd_m; rd_w = vecs[i].rd_w;
      reg_write_e = vecs[i].rw_e; reg_write_m = vecs[i].rw_m; reg_write_w = vecs[i].rw_w;
      load_e = vecs[i].ld; pc_src_e = vecs[i].br;
      mem_req_m = vecs[i].req; mem_ready_m = vecs[i].rdy;
      #1;
      cmp($sformatf("vec%0d ctl", i), 32'(ctl_word()), 32'(vecs[i].exp_ctl));
      cmp($sformatf("vec%0d fwd_a", i), 32'(forward_a_e), 32'(vecs[i].exp_fa));
      cmp($sformatf("vec%0d fwd_b", i), 32'(forward_b_e), 32'(vecs[i].exp_fb));
      step($sformatf("vec%0d", i));
      $display("vec %0d applied: ctl=%h fa=%b fb=%b stall_cycles=%0d", i,
               vecs[i].exp_ctl, vecs[i].exp_fa, vecs[i].exp_fb, stall_cycles);
    end

    // Load-use bubble, then normal flow
    reset_seq();
    load_e = 1; reg_write_e = 1; rd_e = 5; rs2_d = 5;
    step("lu");
    clear_inputs();
    step("lu_next");
    cmp("lu stall_cycles", 32'(stall_cycles), 1);

    // Branch overrides load-use: no fetch stall
    load_e = 1; reg_write_e = 1; rd_e = 5; rs1_d = 5; pc_src_e = 1;
    #1;
    cmp("br_lu ctl", 32'(ctl_word()), 32'(C_BR));
    step("br_lu");
    clear_inputs();
    cmp("br_lu stall_cycles", 32'(stall_cycles), 1);

    // Three-cycle memory wait with a branch that must be ignored
    mem_req_m = 1; mem_ready_m = 0; pc_src_e = 1;
    for (int i = 0; i < 3; i++) step($sformatf("memwait%0d", i));
    mem_ready_m = 1; pc_src_e = 0;
    step("mem_done");
    cmp("memwait stall_cycles", 32'(stall_cycles), 4);
    clear_inputs();
    step("mem_idle");

    // Timeout, sticky flag and counter saturation
    reset_seq();
    mem_req_m = 1; mem_ready_m = 0;
    for (int i = 0; i < 40; i++) begin
      step($sformatf("tmo%0d", i));
      if (i == 3) cmp("tmo before 4th wait", 32'(mem_timeout), 0);
      if (i == 4) cmp("tmo after 4th wait", 32'(mem_timeout), 1);
    end
    cmp("stall saturation", 32'(stall_cycles), STALL_MAX);
    mem_ready_m = 1;
    step("tmo_ready");
    cmp("tmo sticky ready", 32'(mem_timeout), 1);
    clear_inputs();
    step("tmo_idle");
    cmp("tmo sticky idle", 32'(mem_timeout), 1);
    Rst_n = 0;
    #1;
    cmp("tmo cleared by reset", 32'(mem_timeout), 0);
    step("tmo_rst");
    Rst_n = 1;

    // Randomized traffic against the model, with occasional resets
    for (int n = 0; n < 3000; n++) begin
      Rst_n = ($urandom_range(0, 79) != 0);
      rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7));
      rs1_e = 5'($urandom_range(0, 7)); rs2_e = 5'($urandom_range(0, 7));
      rd_e = 5'($urandom_range(0, 7)); rd_m = 5'($urandom_range(0, 7));
      rd_w = 5'($urandom_range(0, 7));
      reg_write_e = 1'($urandom_range(0, 1));
      reg_write_m = 1'($urandom_range(0, 1));
      reg_write_w = 1'($urandom_range(0, 1));
      load_e = ($urandom_range(0, 9) < 4);
      pc_src_e = ($urandom_range(0, 19) < 3);
      mem_req_m = ($urandom_range(0, 9) < 4);
      mem_ready_m = ($urandom_range(0, 9) < 4);
      step($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
